// File: rtl/kbd_pkg.sv
// Shared constants, event packing helper and fetch-state type for the keyboard event controller.
package kbd_pkg;

    localparam logic [7:0] KBD_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] KBD_PREFIX_BRK = 8'hF0;
    localparam int         EVT_W          = 10;
    localparam int         EVT_BRK_BIT    = 9;
    localparam int         EVT_EXT_BIT    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SETTLE = 2'd2
    } kbd_fetch_state_t;

    function automatic logic [EVT_W-1:0] kbd_make_evt(input logic brk, input logic ext,
                                                      input logic [7:0] code);
        logic [EVT_W-1:0] evt;
        evt              = '0;
        evt[EVT_BRK_BIT] = brk;
        evt[EVT_EXT_BIT] = ext;
        evt[7:0]         = code;
        return evt;
    endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// First-word-fall-through event FIFO with a registered head; a pop on a full FIFO
// frees room for a coincident push, a pop on an empty FIFO is ignored.
module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = EVT_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_push_eff;
    logic             w_pop_eff;
    logic [AW-1:0]    w_rd_next;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_head_next;

    // Effective push/pop, next read pointer, next count and the next head word.
    always_comb begin
        w_pop_eff  = i_pop && (r_count != {CW{1'b0}});
        w_push_eff = i_push && ((r_count != CW'(DEPTH)) || i_pop);
        w_rd_next  = w_pop_eff ? (r_rd_ptr + {{(AW-1){1'b0}}, 1'b1}) : r_rd_ptr;
        case ({w_push_eff, w_pop_eff})
            2'b10:   w_count_next = r_count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   w_count_next = r_count - {{(CW-1){1'b0}}, 1'b1};
            default: w_count_next = r_count;
        endcase
        // The incoming word becomes the head when it lands where the head will point.
        if (w_push_eff && (r_wr_ptr == w_rd_next)) begin
            w_head_next = i_data;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Storage array write port.
    always_ff @(posedge i_clk) begin
        if (w_push_eff) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_eff) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_head   <= w_head_next;
        end
    end

    assign o_data  = r_head;
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});

endmodule

// File: rtl/kbd_event_ctrl.sv
// Drains PS/2 scancode bytes, folds E0/F0 prefixes into make/break events and queues them.
// Optional feature macro: KBD_TYPEMATIC_FILTER_EN (suppresses repeated makes of the held key).
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_kbd_ready,
    input  logic                   i_kbd_overflow,
    input  logic [7:0]             i_kbd_data,
    output logic                   o_kbd_read_enable,
    input  logic                   i_evt_pop,
    output logic                   o_evt_valid,
    output logic [EVT_W-1:0]       o_evt_data,
    output logic [$clog2(DEPTH):0] o_evt_count,
    input  logic                   i_status_clr,
    output logic                   o_hw_ovf,
    output logic                   o_fifo_ovf
);
    kbd_fetch_state_t r_state;
    logic             r_rd_en;
    logic             r_ext_f;
    logic             r_brk_f;
    logic             r_hw_ovf;
    logic             r_fifo_ovf;

    logic             w_capture;
    logic             w_is_ext;
    logic             w_is_brk;
    logic             w_complete;
    logic             w_filtered;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [EVT_W-1:0] w_evt;

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic             r_held;
    logic [8:0]       r_held_key;
`endif

    // Byte decode; the FETCH cycle is the capture cycle, so a completing byte pushes right away.
    always_comb begin
        w_capture  = (r_state == ST_FETCH);
        w_is_ext   = w_capture && (i_kbd_data == KBD_PREFIX_EXT);
        w_is_brk   = w_capture && (i_kbd_data == KBD_PREFIX_BRK);
        w_complete = w_capture && !w_is_ext && !w_is_brk;
        w_evt      = kbd_make_evt(r_brk_f, r_ext_f, i_kbd_data);
`ifdef KBD_TYPEMATIC_FILTER_EN
        w_filtered = !r_brk_f && r_held && (r_held_key == {r_ext_f, i_kbd_data});
`else
        w_filtered = 1'b0;
`endif
        w_push     = w_complete && !w_filtered;
        w_drop     = w_push && w_full && !i_evt_pop;
    end

    // Fetch sequencer: one read strobe, then a settle cycle so kbd_ready can refresh.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_rd_en <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_kbd_ready) begin
                        r_state <= ST_FETCH;
                        r_rd_en <= 1'b1;
                    end else begin
                        r_rd_en <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_SETTLE;
                    r_rd_en <= 1'b0;
                end
                ST_SETTLE: begin
                    r_state <= ST_IDLE;
                    r_rd_en <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Prefix accumulation; flags clear on any completing byte, even if the event is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ext_f <= 1'b0;
            r_brk_f <= 1'b0;
        end else if (w_complete) begin
            r_ext_f <= 1'b0;
            r_brk_f <= 1'b0;
        end else begin
            if (w_is_ext) r_ext_f <= 1'b1;
            if (w_is_brk) r_brk_f <= 1'b1;
        end
    end

`ifdef KBD_TYPEMATIC_FILTER_EN
    // Held-key tracking for typematic repeat suppression.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_held     <= 1'b0;
            r_held_key <= 9'h000;
        end else if (w_complete) begin
            if (!r_brk_f) begin
                r_held     <= 1'b1;
                r_held_key <= {r_ext_f, i_kbd_data};
            end else if (r_held_key == {r_ext_f, i_kbd_data}) begin
                r_held     <= 1'b0;
            end
        end
    end
`endif

    // Sticky status flags; a set condition beats a coincident clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hw_ovf   <= 1'b0;
            r_fifo_ovf <= 1'b0;
        end else begin
            if (i_kbd_overflow)    r_hw_ovf <= 1'b1;
            else if (i_status_clr) r_hw_ovf <= 1'b0;
            if (w_drop)            r_fifo_ovf <= 1'b1;
            else if (i_status_clr) r_fifo_ovf <= 1'b0;
        end
    end

    kbd_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (i_evt_pop),
        .i_data  (w_evt),
        .o_data  (o_evt_data),
        .o_count (o_evt_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_kbd_read_enable = r_rd_en;
    assign o_evt_valid       = !w_empty;
    assign o_hw_ovf          = r_hw_ovf;
    assign o_fifo_ovf        = r_fifo_ovf;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Self-checking bench: an emulated PS/2 receiver feeds bytes, a scancode-level model predicts events.
module tb_kbd_event_ctrl;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             kbd_ready = 1'b0;
    logic             kbd_overflow = 1'b0;
    logic [7:0]       kbd_data = 8'h00;
    logic             kbd_read_enable;
    logic             evt_pop = 1'b0;
    logic             evt_valid;
    logic [9:0]       evt_data;
    logic [CW-1:0]    evt_count;
    logic             status_clr = 1'b0;
    logic             hw_ovf;
    logic             fifo_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q [$];
    logic [7:0] tx   [$];
    logic [9:0] exp_q[$];
    logic       rx_pop_pending = 1'b0;

    // behavioural model state
    logic       m_ext = 1'b0, m_brk = 1'b0, m_held = 1'b0, m_fovf = 1'b0;
    logic [8:0] m_hkey = 9'h000;

    // read-strobe monitor
    int cyc = 0;
    int rd_pulses = 0;
    int rd_viol = 0;
    int last_pulse = -100;
    logic rd_prev = 1'b0;

    kbd_event_ctrl #(.DEPTH(DEPTH)) dut (
        .i_clk (clk), .i_rst (rst), .i_kbd_ready (kbd_ready), .i_kbd_overflow (kbd_overflow),
        .i_kbd_data (kbd_data), .o_kbd_read_enable (kbd_read_enable), .i_evt_pop (evt_pop),
        .o_evt_valid (evt_valid), .o_evt_data (evt_data), .o_evt_count (evt_count),
        .i_status_clr (status_clr), .o_hw_ovf (hw_ovf), .o_fifo_ovf (fifo_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver emulation: head byte retires the cycle after the strobe.
    always @(negedge clk) begin
        if (rx_pop_pending && rx_q.size() > 0) rx_q.delete(0);
        rx_pop_pending = kbd_read_enable;
        if (kbd_read_enable) begin
            if (rd_prev || (cyc - last_pulse) < 3) rd_viol++;
            last_pulse = cyc;
            rd_pulses++;
        end
        rd_prev   = kbd_read_enable;
        kbd_ready = (rx_q.size() != 0);
        kbd_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        exp_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_held = 1'b0; m_fovf = 1'b0; m_hkey = 9'h000;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic keep;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            keep = 1'b1;
`ifdef KBD_TYPEMATIC_FILTER_EN
            if (!m_brk) begin
                if (m_held && m_hkey == {m_ext, b}) keep = 1'b0;
                m_held = 1'b1;
                m_hkey = {m_ext, b};
            end else if (m_held && m_hkey == {m_ext, b}) begin
                m_held = 1'b0;
            end
`endif
            if (keep) begin
                if (exp_q.size() >= DEPTH) m_fovf = 1'b1;
                else exp_q.push_back({m_brk, m_ext, b});
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic send_tx();
        @(posedge clk);
        #1;
        foreach (tx[i]) begin
            rx_q.push_back(tx[i]);
            model_byte(tx[i]);
        end
    endtask

    task automatic wait_drain(input string name);
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            @(negedge clk);
            quiet = (rx_q.size() == 0 && !kbd_read_enable) ? quiet + 1 : 0;
        end
        n_checks++;
        if (quiet < 3) begin
            n_fail++;
            $display("FAIL %s_drain: receiver still holds %0d bytes, required 0", name, rx_q.size());
        end
    endtask

    task automatic wait_strobe(input string name, output logic found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = kbd_read_enable;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s_strobe: kbd_read_enable never rose", name);
        end
    endtask

    task automatic pop_check(input string name, output logic [9:0] got);
        logic [9:0] e;
        int c;
        @(negedge clk);
        c = exp_q.size();
        e = (c > 0) ? exp_q.pop_front() : 10'h000;
        got = evt_data;
        n_checks++;
        if (c == 0 || evt_valid !== 1'b1 || evt_data !== e) begin
            n_fail++;
            $display("FAIL %s_head: valid=%b data=%h, required valid=1 data=%h (model held %0d)",
                     name, evt_valid, evt_data, e, c);
        end
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
        n_checks++;
        if (evt_count !== CW'(c > 0 ? c - 1 : 0)) begin
            n_fail++;
            $display("FAIL %s_count: count=%0d, required %0d", name, evt_count, (c > 0 ? c - 1 : 0));
        end
    endtask

    task automatic pop_all(input string name);
        logic [9:0] g;
        while (exp_q.size() > 0) pop_check(name, g);
    endtask

    task automatic check_count(input string name);
        n_checks++;
        if (evt_count !== CW'(exp_q.size()) || fifo_ovf !== m_fovf) begin
            n_fail++;
            $display("FAIL %s: count=%0d fifo_ovf=%b, required count=%0d fifo_ovf=%b",
                     name, evt_count, fifo_ovf, exp_q.size(), m_fovf);
        end
    endtask

    task automatic test_reset(input string name);
        @(negedge clk);
        rst = 1'b0; evt_pop = 1'b0; status_clr = 1'b0; kbd_overflow = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({kbd_read_enable, evt_valid, evt_count, hw_ovf, fifo_ovf, evt_data} !== '0) begin
            n_fail++;
            $display("FAIL %s: rd=%b valid=%b count=%0d hw=%b fifo=%b data=%h, required all zero",
                     name, kbd_read_enable, evt_valid, evt_count, hw_ovf, fifo_ovf, evt_data);
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_latency();
        @(posedge clk);
        #1;
        rx_q.push_back(8'h1C);
        model_byte(8'h1C);
        @(negedge clk);
        n_checks++;
        if (kbd_read_enable !== 1'b0 || evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_n: rd=%b valid=%b, required 0 0", kbd_read_enable, evt_valid);
        end
        @(negedge clk);
        n_checks++;
        if (kbd_read_enable !== 1'b1 || evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_n1: rd=%b valid=%b, required 1 0", kbd_read_enable, evt_valid);
        end
        @(negedge clk);
        n_checks++;
        if (kbd_read_enable !== 1'b0 || evt_valid !== 1'b1 || evt_data !== 10'h01C) begin
            n_fail++;
            $display("FAIL latency_n2: rd=%b valid=%b data=%h, required 0 1 01C",
                     kbd_read_enable, evt_valid, evt_data);
        end
        wait_drain("latency");
        pop_all("latency");
    endtask

    task automatic test_basic_stream();
        rd_pulses = 0;
        rd_viol   = 0;
        tx = {8'h1C, 8'hF0, 8'h1C};
        send_tx();
        wait_drain("basic");
        n_checks++;
        if (rd_pulses != 3 || rd_viol != 0) begin
            n_fail++;
            $display("FAIL basic_strobes: pulses=%0d spacing_errors=%0d, required 3 and 0", rd_pulses, rd_viol);
        end
        check_count("basic_count");
        pop_all("basic");
    endtask

    task automatic test_prefixes();
        logic [9:0] g;
        tx = {8'hE0, 8'hF0, 8'h75};
        send_tx(); wait_drain("pfx_a");
        pop_check("pfx_a", g);
        n_checks++;
        if (g !== 10'h375) begin n_fail++; $display("FAIL pfx_e0f075: got %h, required 375", g); end
        tx = {8'hE0, 8'h75};
        send_tx(); wait_drain("pfx_b");
        pop_check("pfx_b", g);
        n_checks++;
        if (g !== 10'h175) begin n_fail++; $display("FAIL pfx_e075: got %h, required 175", g); end
        tx = {8'hF0, 8'hE0, 8'hE0, 8'h74};
        send_tx(); wait_drain("pfx_c");
        pop_check("pfx_c", g);
        n_checks++;
        if (g !== 10'h374) begin n_fail++; $display("FAIL pfx_f0e074: got %h, required 374", g); end
    endtask

    task automatic test_random();
        for (int b = 0; b < 5; b++) begin
            int n_ev = $urandom_range(1, DEPTH);
            int ev = 0;
            int r;
            tx.delete();
            while (ev < n_ev) begin
                r = $urandom_range(0, 9);
                if (r == 0) tx.push_back(8'hE0);
                else if (r == 1) tx.push_back(8'hF0);
                else begin
                    tx.push_back(8'($urandom_range(1, 223)));
                    ev++;
                end
            end
            send_tx();
            wait_drain("rand");
            check_count("rand_count");
            pop_all("rand");
        end
    endtask

    task automatic test_full_overflow();
        test_reset("full_reset");
        tx.delete();
        for (int i = 0; i < DEPTH; i++) tx.push_back(8'(8'h10 + i));
        send_tx(); wait_drain("full_fill");
        tx = {8'h29};
        send_tx(); wait_drain("full_extra");
        n_checks++;
        if (fifo_ovf !== 1'b1 || evt_count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL full_ovf: fifo_ovf=%b count=%0d, required 1 %0d", fifo_ovf, evt_count, DEPTH);
        end
        pop_all("full_drain");
        @(negedge clk); status_clr = 1'b1;
        @(negedge clk); status_clr = 1'b0; m_fovf = 1'b0;
        n_checks++;
        if (fifo_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL full_clr: fifo_ovf=%b, required 0", fifo_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        logic found;
        logic [9:0] g;
        tx.delete();
        for (int i = 0; i < DEPTH; i++) tx.push_back(8'(8'h30 + i));
        send_tx(); wait_drain("fpp_fill");
        @(posedge clk); #1;
        rx_q.push_back(8'h5A);
        wait_strobe("fpp", found);
        if (found) begin
            n_checks++;
            if (evt_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL fpp_head: data=%h, required %h", evt_data, exp_q[0]);
            end
            evt_pop = 1'b1;
            void'(exp_q.pop_front());
            model_byte(8'h5A);
            @(negedge clk);
            evt_pop = 1'b0;
            check_count("fpp_count");
        end
        wait_drain("fpp");
        g = 10'h000;
        while (exp_q.size() > 0) pop_check("fpp_drain", g);
        n_checks++;
        if (g !== 10'h05A) begin n_fail++; $display("FAIL fpp_last: got %h, required 05A", g); end
    endtask

    task automatic test_empty_boundary();
        logic found;
        logic [9:0] d;
        @(posedge clk); #1;
        rx_q.push_back(8'h7E);
        wait_strobe("emp", found);
        if (found) begin
            evt_pop = 1'b1;
            model_byte(8'h7E);
            @(negedge clk);
            evt_pop = 1'b0;
            n_checks++;
            if (evt_count !== CW'(1) || evt_data !== 10'h07E) begin
                n_fail++;
                $display("FAIL empty_push_pop: count=%0d data=%h, required 1 07E", evt_count, evt_data);
            end
        end
        wait_drain("emp");
        pop_all("emp");
        @(negedge clk);
        d = evt_data;
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
        @(negedge clk);
        n_checks++;
        if (evt_count !== CW'(0) || evt_valid !== 1'b0 || evt_data !== d) begin
            n_fail++;
            $display("FAIL empty_pop: count=%0d valid=%b data=%h, required 0 0 %h", evt_count, evt_valid, evt_data, d);
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] g;
        tx = {8'hE0};
        send_tx(); wait_drain("mid_e0");
        test_reset("mid_reset_outputs");
        tx = {8'h6B};
        send_tx(); wait_drain("mid_6b");
        pop_check("mid", g);
        n_checks++;
        if (g !== 10'h06B) begin n_fail++; $display("FAIL mid_reset_evt: got %h, required 06B", g); end
    endtask

    task automatic test_sticky_hw();
        @(negedge clk); kbd_overflow = 1'b1;
        @(negedge clk); kbd_overflow = 1'b0;
        n_checks++;
        if (hw_ovf !== 1'b1) begin n_fail++; $display("FAIL hw_set: hw_ovf=%b, required 1", hw_ovf); end
        kbd_overflow = 1'b1; status_clr = 1'b1;
        @(negedge clk); kbd_overflow = 1'b0; status_clr = 1'b0;
        n_checks++;
        if (hw_ovf !== 1'b1) begin n_fail++; $display("FAIL hw_set_wins: hw_ovf=%b, required 1", hw_ovf); end
        status_clr = 1'b1;
        @(negedge clk); status_clr = 1'b0;
        n_checks++;
        if (hw_ovf !== 1'b0) begin n_fail++; $display("FAIL hw_clr: hw_ovf=%b, required 0", hw_ovf); end
    endtask

    task automatic test_typematic();
        int want;
        test_reset("typ_reset");
`ifdef KBD_TYPEMATIC_FILTER_EN
        want = 3;
`else
        want = 5;
`endif
        tx = {8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        send_tx(); wait_drain("typ");
        n_checks++;
        if (evt_count !== CW'(want) || fifo_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL typ_count: count=%0d fifo_ovf=%b, required %0d 0", evt_count, fifo_ovf, want);
        end
        pop_all("typ");
    endtask

    initial begin
        test_reset("reset");
        test_latency();
        test_basic_stream();
        test_prefixes();
        test_random();
        test_full_overflow();
        test_full_push_pop();
        test_empty_boundary();
        test_mid_reset();
        test_sticky_hw();
        test_typematic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Keyboard-side controller between the PS/2 receiver (`ps2_kbd`) and the CPU's memory-mapped keyboard port. It sequences `kbd_read_enable` to drain raw scancode bytes from the receiver and folds `E0`/`F0` prefixes into single make/break events. Completed events are buffered in a first-word-fall-through FIFO for the CPU to pop at its own pace. It runs in the CPU clock domain and sits beside `ps2_kbd`.

## Interface
- `DEPTH`, 8: event FIFO depth; power of two, ≥2.
- `clk`  in  1  CPU clock, same clock as `ps2_kbd`.
- `rst`  in  1  synchronous, active-low reset.
- `kbd_ready`  in  1  receiver holds at least one byte.
- `kbd_overflow`  in  1  receiver's internal buffer overflowed.
- `kbd_data`  in  8  receiver head byte; valid while `kbd_ready`=1.
- `kbd_read_enable`  out  1  one-cycle pop strobe to receiver.
- `evt_pop`  in  1  CPU consumes head event; ignored when empty.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_data`  out  10  head event: [9]=break, [8]=extended, [7:0]=scancode.
- `evt_count`  out  $clog2(DEPTH)+1  events held, 0..DEPTH.
- `status_clr`  in  1  clears both sticky flags.
- `hw_ovf`  out  1  sticky; set when `kbd_overflow`=1 on any cycle.
- `fifo_ovf`  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- Fetch FSM, states IDLE, FETCH, SETTLE.
  - IDLE → FETCH when `kbd_ready`=1.
  - FETCH: `kbd_read_enable`=1 (registered); `kbd_data` captured at the end of this cycle; → SETTLE.
  - SETTLE: wait one cycle for the receiver to update `kbd_ready`; → IDLE.
  - Result: at most one byte per 3 cycles.
- Decoder runs on each captured byte:
  - `8'hE0`: set `ext_f`; no event.
  - `8'hF0`: set `brk_f`; no event.
  - Any other byte: emit event {`brk_f`, `ext_f`, byte}, then clear both flags.
  - Prefixes accumulate in any order. A repeated prefix is idempotent.
- FIFO push happens in the same cycle the completing byte is captured.
- Full FIFO:
  - If an event completes with `evt_count`=DEPTH and no `evt_pop` that cycle, the event is dropped, `fifo_ovf` is set, and the prefix flags are still cleared.
  - If `evt_pop` and a push coincide while full, both take effect; nothing is dropped and the count is unchanged.
- Empty FIFO: `evt_pop` is a no-op; `evt_data` is don't-care but stable.
- Simultaneous push and pop with count between 1 and DEPTH−1: count unchanged; the head advances.
- Push into an empty FIFO with a coincident `evt_pop`: the pop is ignored and the new event stays.
- Sticky flags: if `status_clr` coincides with a set condition, set wins.
- Reset (`rst`=0 at a clock edge), including mid-sequence:
  - FSM → IDLE, FIFO emptied, `ext_f`/`brk_f` cleared, both sticky flags cleared.
  - A partially received prefix sequence is lost.
  - `ps2_kbd` itself is not reset by this block.

## Timing
- Reset values: `kbd_read_enable`=0, `evt_valid`=0, `evt_count`=0, `hw_ovf`=0, `fifo_ovf`=0, `evt_data`=10'h000.
- Latency: `kbd_ready` sampled high in IDLE at cycle N → `kbd_read_enable` high in N+1 → `evt_valid` high in N+2 (when the byte completes an event into an empty FIFO).
- `evt_data`/`evt_valid`/`evt_count` are registered FIFO state; `evt_pop` in cycle M updates them in cycle M+1.
- `kbd_read_enable` is never high on two consecutive cycles.

## Configuration
- `KBD_TYPEMATIC_FILTER_EN`:
  - Defined: the block keeps the last make event {ext, code} plus a held bit.
    - A make event equal to the held key while held=1 is discarded: no push, no `fifo_ovf`.
    - A break event for the held key clears held.
    - A different make event replaces the held key.
    - Reset clears held.
  - Undefined: every decoded event is pushed, including typematic repeats.

## Structure
- Package `kbd_pkg`:
  - `KBD_PREFIX_EXT`=8'hE0, `KBD_PREFIX_BRK`=8'hF0.
  - Event field positions `EVT_BRK_BIT`=9, `EVT_EXT_BIT`=8.
  - Fetch-state enum `kbd_fetch_state_t`.
- Sub-module `kbd_evt_fifo`:
  - Synchronous first-word-fall-through FIFO, parameters `DEPTH` and width 10.
  - Ports: push, pop, data in/out, count, full, empty.
  - Handles simultaneous push/pop at the full and empty boundaries as specified above.

## Test plan
- Byte stream 1C, F0 1C → events 0x01C then 0x21C. `kbd_read_enable` pulses exactly 3 times, each a single cycle, at least 3 cycles apart.
- Stream E0 F0 75 → a single event 0x375. E0 75 → 0x175. F0 E0 74 → 0x374 (prefix order irrelevant).
- Fill with DEPTH events and no pops, then one more byte 29 → `fifo_ovf`=1 and `evt_count`=DEPTH. Pop all → head sequence matches the first DEPTH events. Then assert `status_clr` with no new overflow → `fifo_ovf`=0.
- FIFO full, push 0x05A with a coincident `evt_pop` → count stays DEPTH, `fifo_ovf` stays 0, and the last popped entry is 0x05A.
- Send E0 then pull `rst` low for one cycle, then send 6B → event 0x06B (extended flag lost). All outputs are at reset values during reset.
- Macro defined: stream 1C 1C 1C F0 1C 1C → events 0x01C, 0x21C, 0x01C. Macro undefined → five events.
